// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Brief    : Pong game sequencer: FSM, BCD score, balls-left and pause timer.
// Revision : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
  parameter int BALLS        = 3,
  parameter int PAUSE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       btn_start,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic       ball_reset,
  output logic       game_over,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [1:0] balls_left,
  output logic       timer_zero
);

  localparam logic [1:0] C_BALLS = 2'(BALLS);
  localparam logic [7:0] C_PAUSE = 8'(PAUSE_FRAMES);

  typedef enum logic [1:0] {
    S_NEWGAME = 2'd0,
    S_PLAY    = 2'd1,
    S_NEWBALL = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t     state_q;
  logic       gra_still_q;
  logic       ball_reset_q;
  logic       game_over_q;
  logic [3:0] dig1_q;
  logic [3:0] dig0_q;
  logic [3:0] dig1_d;
  logic [3:0] dig0_d;
  logic [1:0] balls_q;
  logic [7:0] timer_q;
  logic       timer_zero_q;
  logic       start_prev_q;
  logic       start_edge;

  assign start_edge = btn_start & ~start_prev_q;

  // Saturating BCD increment; 99 holds.
  always_comb begin
    dig1_d = dig1_q;
    dig0_d = dig0_q;
    if (dig0_q == 4'd9) begin
      if (dig1_q != 4'd9) begin
        dig0_d = 4'd0;
        dig1_d = dig1_q + 4'd1;
      end
    end else begin
      dig0_d = dig0_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_NEWGAME;
      gra_still_q  <= 1'b1;
      ball_reset_q <= 1'b0;
      game_over_q  <= 1'b0;
      dig1_q       <= 4'd0;
      dig0_q       <= 4'd0;
      balls_q      <= C_BALLS;
      timer_q      <= 8'd0;
      timer_zero_q <= 1'b1;
      start_prev_q <= 1'b1;
    end else begin
      start_prev_q <= btn_start;
      ball_reset_q <= 1'b0;

      // Free-running frame countdown; a load below overrides it.
      if (refr_tick && (timer_q != 8'd0)) begin
        timer_q      <= timer_q - 8'd1;
        timer_zero_q <= (timer_q == 8'd1);
      end

      case (state_q)
        S_NEWGAME: begin
          if (start_edge) begin
            dig1_q       <= 4'd0;
            dig0_q       <= 4'd0;
            balls_q      <= C_BALLS;
            state_q      <= S_PLAY;
            gra_still_q  <= 1'b0;
            ball_reset_q <= 1'b1;
          end
        end
        S_PLAY: begin
          if (miss) begin
            balls_q      <= balls_q - 2'd1;
            gra_still_q  <= 1'b1;
            timer_q      <= C_PAUSE;
            timer_zero_q <= (C_PAUSE == 8'd0);
            if (balls_q == 2'd1) begin
              state_q     <= S_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= S_NEWBALL;
            end
          end else if (hit) begin
            dig1_q <= dig1_d;
            dig0_q <= dig0_d;
          end
        end
        S_NEWBALL: begin
          // Start must see a timer that had already expired.
          if (timer_zero_q && start_edge) begin
            state_q      <= S_PLAY;
            gra_still_q  <= 1'b0;
            ball_reset_q <= 1'b1;
          end
        end
        S_OVER: begin
          if (timer_zero_q) begin
            state_q     <= S_NEWGAME;
            game_over_q <= 1'b0;
          end
        end
        default: state_q <= S_NEWGAME;
      endcase
    end
  end

  assign gra_still  = gra_still_q;
  assign ball_reset = ball_reset_q;
  assign game_over  = game_over_q;
  assign dig1       = dig1_q;
  assign dig0       = dig0_q;
  assign balls_left = balls_q;
  assign timer_zero = timer_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Brief    : Randomized self-checking bench against a behavioural game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

  localparam int BALLS = 3;
  localparam int PAUSE = 120;

  localparam int M_NEWGAME = 0;
  localparam int M_PLAY    = 1;
  localparam int M_NEWBALL = 2;
  localparam int M_OVER    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       refr_tick = 1'b0;
  logic       btn_start = 1'b1;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still, ball_reset, game_over, timer_zero;
  logic [3:0] dig1, dig0;
  logic [1:0] balls_left;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural game model: score as an integer, timer as a frame count.
  int  m_mode, m_score, m_balls, m_timer;
  bit  m_prev, m_pulse;

  pong_game_ctrl #(.BALLS(BALLS), .PAUSE_FRAMES(PAUSE)) dut (
    .clk       (clk),
    .reset     (reset),
    .refr_tick (refr_tick),
    .btn_start (btn_start),
    .hit       (hit),
    .miss      (miss),
    .gra_still (gra_still),
    .ball_reset(ball_reset),
    .game_over (game_over),
    .dig1      (dig1),
    .dig0      (dig0),
    .balls_left(balls_left),
    .timer_zero(timer_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_NEWGAME;
    m_score = 0;
    m_balls = BALLS;
    m_timer = 0;
    m_prev  = 1'b1;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit h, input bit ms, input bit tk);
    bit edge_s, expired, load;
    edge_s  = st && !m_prev;
    m_prev  = st;
    expired = (m_timer == 0);
    load    = 1'b0;
    m_pulse = 1'b0;
    if (m_mode == M_NEWGAME) begin
      if (edge_s) begin
        m_score = 0; m_balls = BALLS; m_mode = M_PLAY; m_pulse = 1'b1;
      end
    end else if (m_mode == M_PLAY) begin
      if (ms) begin
        m_balls = m_balls - 1;
        m_mode  = (m_balls == 0) ? M_OVER : M_NEWBALL;
        load    = 1'b1;
      end else if (h && m_score < 99) begin
        m_score = m_score + 1;
      end
    end else if (m_mode == M_NEWBALL) begin
      if (expired && edge_s) begin
        m_mode = M_PLAY; m_pulse = 1'b1;
      end
    end else begin
      if (expired) m_mode = M_NEWGAME;
    end
    if (load) m_timer = PAUSE;
    else if (tk && m_timer > 0) m_timer = m_timer - 1;
  endtask

  task automatic check_all();
    chk("gra_still",  int'(gra_still),  int'(m_mode != M_PLAY));
    chk("ball_reset", int'(ball_reset), int'(m_pulse));
    chk("game_over",  int'(game_over),  int'(m_mode == M_OVER));
    chk("dig1",       int'(dig1),       m_score / 10);
    chk("dig0",       int'(dig0),       m_score % 10);
    chk("balls_left", int'(balls_left), m_balls);
    chk("timer_zero", int'(timer_zero), int'(m_timer == 0));
  endtask

  task automatic step(input bit st, input bit h, input bit ms, input bit tk);
    btn_start = st; hit = h; miss = ms; refr_tick = tk;
    @(posedge clk);
    if (reset) model_edge(st, h, ms, tk);
    #1;
    check_all();
  endtask

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  // p_st: probability the button is held this cycle.
  task automatic run_phase(input int n, input int p_st, input int p_hit,
                           input int p_miss, input int p_tick);
    for (int i = 0; i < n; i++)
      step(pct(p_st), pct(p_hit), pct(p_miss), pct(p_tick));
  endtask

  task automatic press_start();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset_mid();
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) step(1'b1, pct(50), pct(20), pct(50));
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    // Button held through reset must not start a game.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, pct(50), pct(50), pct(50));
    press_start();
    // Drive score to saturation.
    run_phase(110, 0, 100, 0, 30);
    // Hit and miss together.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    // Early start during pause, then wait out the timer and restart.
    run_phase(60, 0, 0, 0, 100);
    press_start();
    run_phase(80, 0, 0, 0, 100);
    press_start();
    run_phase(40, 0, 40, 0, 50);
    async_reset_mid();
    run_phase(20, 0, 100, 0, 50);

    for (int r = 0; r < 12; r++) begin
      run_phase(1500, 8, 35, 2, 60);
      run_phase(300, 10, 30, 25, 80);
      if (r % 3 == 1) async_reset_mid();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game sequencer for the Pong display path. It runs the game state machine (new game, play, ball lost, game over), keeps the BCD score and the balls-remaining count, and times the pauses between balls. Frame timing comes from the VGA sync frame tick. Its outputs freeze and recenter the ball/paddle graphics datapath and feed the score and "game over" text overlay.

Parameters:
BALLS, 3, balls per game (1..3; balls_left is 2 bits).
PAUSE_FRAMES, 120, frames of enforced pause after a miss or at game over (2 s at 60 Hz; 1..255).

Ports:
clk  input  1  system clock (pixel-logic clock)
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
refr_tick  input  1  one-cycle pulse per frame from vga sync at start of vertical blanking
btn_start  input  1  debounced, synchronous start button level (1 = pressed)
hit  input  1  one-cycle pulse: ball struck paddle (from graphics datapath)
miss  input  1  one-cycle pulse: ball passed paddle
gra_still  output  1  1 = freeze ball motion in graphics datapath
ball_reset  output  1  one-cycle pulse: recenter ball and restore default velocity
game_over  output  1  1 while in OVER state
dig1  output  4  score tens, BCD
dig0  output  4  score units, BCD
balls_left  output  2  balls remaining
timer_zero  output  1  1 when pause timer is 0 (drives "press start" prompt)

Behaviour:
- All outputs registered; async reset (reset=0) forces state=NEWGAME, gra_still=1, ball_reset=0, game_over=0, dig1=dig0=0, balls_left=BALLS, timer=0, timer_zero=1, start_prev=1.
- Start edge: start_edge = btn_start & ~start_prev; start_prev registered each cycle. Resetting start_prev to 1 means a button held through reset does not start a game until it is released and pressed again.
- Pause timer: 8-bit down counter. On refr_tick, it decrements when nonzero and holds at 0. It loads PAUSE_FRAMES on entry to NEWBALL or OVER.
- States:
  - NEWGAME: gra_still=1, game_over=0. On start_edge: dig1=dig0=0, balls_left=BALLS, go to PLAY.
  - PLAY: gra_still=0.
    - On hit: BCD increment of score. dig0 9→0 carries into dig1. At 99 the score saturates and holds 99.
    - On miss: balls_left decrements. If balls_left was 1, go to OVER (balls_left=0); otherwise go to NEWBALL. In both cases load the timer.
  - NEWBALL: gra_still=1. When timer==0 and start_edge, go to PLAY. A start_edge while timer≠0 is ignored and not remembered.
  - OVER: gra_still=1, game_over=1. When timer reaches 0, go to NEWGAME automatically. Score is kept on display until the next start.
- ball_reset is asserted for exactly one cycle on every transition into PLAY, in the same cycle the state register shows PLAY. It is never asserted in any other cycle.
- Latency: an input event sampled at edge N is reflected in state and outputs after edge N.
- Simultaneous events:
  - hit and miss in the same cycle: miss wins, hit is ignored, score unchanged.
  - hit/miss outside PLAY: ignored.
  - refr_tick concurrent with a timer load: the load wins.
  - start_edge while timer reaches 0 on the same cycle (NEWBALL): not accepted; timer_zero must already be 1 when start_edge is sampled.
- Reset mid-game: immediate return to the reset values above, with no ball_reset pulse.
- timer_zero = (timer==0), registered alongside the timer.

Test Plan:
1. Reset held low 3 cycles with btn_start=1, then released with btn_start held high for 10 cycles → state stays NEWGAME, no ball_reset. Release and press → one ball_reset pulse, gra_still=0, balls_left=3, score 00.
2. In PLAY, 12 hit pulses → dig1=1, dig0=2. Continue to 99 hits total, plus 5 more → score holds 9/9.
3. Hit and miss in the same cycle with score 05, balls_left=3 → score stays 05, balls_left=2, state NEWBALL, gra_still=1, timer=120.
4. NEWBALL: press start after 50 refr_ticks → ignored. After 120 ticks timer_zero=1; press start → PLAY, single ball_reset pulse.
5. Third miss → game_over=1, balls_left=0. After 120 refr_ticks → NEWGAME, game_over=0, score retained. Next start clears score to 00 and sets balls_left=3.
6. Assert reset asynchronously (off clock edge) mid-PLAY with score 37 → outputs return to reset values immediately. hit pulses before the next start are ignored.
